// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream stage.
package fifo_stream_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FRAME_LEN_DEF  = 16;
  localparam int BUF_DEPTH      = 3;
  localparam int FRAME_CNT_W    = 16;
  localparam int OCC_W          = 2;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } buf_op_e;

  // Word index width; a single-word frame still needs one bit of register.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  function automatic logic [OCC_W-1:0] ptr_inc(input logic [OCC_W-1:0] p);
    return (p == OCC_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/stream_hold_buf.sv
// Three-entry register ring buffer: absorbs the FIFO read latency and
// presents its oldest word at head.
module stream_hold_buf
  import fifo_stream_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic [OCC_W-1:0]      occ
);

  logic [data_width-1:0] mem [BUF_DEPTH];
  logic [OCC_W-1:0]      wr_ptr;
  logic [OCC_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  buf_op_e               op;

  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != OCC_W'(BUF_DEPTH)) || do_pop);

  // NOTE: the default assignment comes first so no path leaves op unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    op = OP_IDLE;
    case ({do_push, do_pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // NOTE: storage is cleared on reset on purpose, so the stream data output
  // reads as zero after reset instead of exposing discarded words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case (op)
        OP_PUSH: occ <= occ + 1'b1;
        OP_POP:  occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO drain stage: issues read strobes against buffer credit and streams the
// words out as valid/ready with m_last every FRAME_LEN words.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [data_width-1:0]  fifo_rd_data,
  output logic [data_width-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = idx_width(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic                   inflight;
  logic [OCC_W-1:0]       occ;
  logic [OCC_W:0]         owned;
  logic [data_width-1:0]  head;
  logic [IDX_W-1:0]       word_idx;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic                   handshake;

  stream_hold_buf #(
    .data_width(data_width)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (handshake),
    .head     (head),
    .occ      (occ)
  );

  // Credit counts words already held plus the one still in the FIFO read
  // pipeline; only registered state feeds it, so m_ready never reaches rd_en.
  assign owned      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (owned < (OCC_W + 1)'(BUF_DEPTH));

  assign m_valid   = !rst && (occ != '0);
  assign m_data    = rst ? '0 : head;
  assign m_last    = m_valid && (word_idx == LAST_IDX);
  assign handshake = m_valid && m_ready;
  assign frame_cnt = frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx <= '0;
      frame_q  <= '0;
    end else if (handshake) begin
      if (m_last) begin
        word_idx <= '0;
        frame_q  <= frame_q + 1'b1;
      end else begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule
